// File: rtl/radio_seq_pkg.sv
// Shared types and default timing for the radio enable sequencer.
// State encodings double as the debug state_o value.
package radio_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LDO_UP = 3'd1,
        S_PLL_UP = 3'd2,
        S_GAP    = 3'd3,
        S_ACTIVE = 3'd4,
        S_PWR_DN = 3'd5
    } state_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LDO_SETTLE  = 20;
    localparam int DEF_PLL_TIMEOUT = 200;
    localparam int DEF_SWITCH_GAP  = 4;
    localparam int DEF_PWRDN_HOLD  = 8;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that saturates at zero.
// Shared by every timed state of the sequencer.
module seq_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/radio_enable_sequencer.sv
// Radio front-end power sequencer: LDO, PLL, lock wait, then RX/TX path.
// All outputs registered; break-before-make on direction change.
module radio_enable_sequencer
    import radio_seq_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LDO_SETTLE  = DEF_LDO_SETTLE,
    parameter int PLL_TIMEOUT = DEF_PLL_TIMEOUT,
    parameter int SWITCH_GAP  = DEF_SWITCH_GAP,
    parameter int PWRDN_HOLD  = DEF_PWRDN_HOLD
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       radio_en_s2,
    input  logic       rx_en_s2,
    input  logic       pll_lock,
    input  logic       clr_err,
    output logic       ldo_en,
    output logic       pll_en,
    output logic       rx_path_en,
    output logic       tx_path_en,
    output logic       radio_ready,
    output logic       timeout_err,
    output logic [2:0] state_o
);

    localparam int MAX_CNT = (1 << CNT_W) - 1;

    if (LDO_SETTLE < 1 || LDO_SETTLE > MAX_CNT ||
        PLL_TIMEOUT < 1 || PLL_TIMEOUT > MAX_CNT ||
        SWITCH_GAP < 1 || SWITCH_GAP > MAX_CNT ||
        PWRDN_HOLD < 1 || PWRDN_HOLD > MAX_CNT) begin : g_bad_param
        $error("radio_enable_sequencer: timing parameter out of range");
    end

    localparam logic [CNT_W-1:0] LD_LDO = CNT_W'(LDO_SETTLE - 1);
    localparam logic [CNT_W-1:0] LD_PLL = CNT_W'(PLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(SWITCH_GAP - 1);
    localparam logic [CNT_W-1:0] LD_PD  = CNT_W'(PWRDN_HOLD - 1);

    state_t r_state;
    logic   r_ldo_en;
    logic   r_pll_en;
    logic   r_rx_en;
    logic   r_tx_en;
    logic   r_ready;
    logic   r_err;
    logic   r_lockout;
    logic   r_dir;

    state_t           w_nxt_state;
    logic             w_ldo_en;
    logic             w_pll_en;
    logic             w_rx_en;
    logic             w_tx_en;
    logic             w_ready;
    logic             w_lockout;
    logic             w_dir;
    logic             w_set_err;
    logic             w_go_pd;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;

    seq_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk      (ck),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (!w_load),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_ldo_en    = r_ldo_en;
        w_pll_en    = r_pll_en;
        w_rx_en     = r_rx_en;
        w_tx_en     = r_tx_en;
        w_ready     = r_ready;
        w_lockout   = r_lockout;
        w_dir       = r_dir;
        w_set_err   = 1'b0;
        w_go_pd     = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (!radio_en_s2) begin
                    w_lockout = 1'b0;
                end else if (!r_lockout) begin
                    w_nxt_state = S_LDO_UP;
                    w_ldo_en    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = LD_LDO;
                end
            end
            S_LDO_UP: begin
                if (!radio_en_s2) begin
                    w_go_pd = 1'b1;
                end else if (w_zero) begin
                    w_nxt_state = S_PLL_UP;
                    w_pll_en    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = LD_PLL;
                end
            end
            S_PLL_UP: begin
                if (!radio_en_s2) begin
                    w_go_pd = 1'b1;
                end else if (pll_lock) begin
                    w_nxt_state = S_GAP;
                    w_load      = 1'b1;
                    w_load_val  = LD_GAP;
                end else if (w_zero) begin
                    w_set_err = 1'b1;
                    w_lockout = 1'b1;
                    w_go_pd   = 1'b1;
                end
            end
            S_GAP: begin
                if (!radio_en_s2) begin
                    w_go_pd = 1'b1;
                end else if (w_zero) begin
                    w_nxt_state = S_ACTIVE;
                    w_rx_en     = rx_en_s2;
                    w_tx_en     = !rx_en_s2;
                    w_ready     = 1'b1;
                    w_dir       = rx_en_s2;
                end
            end
            S_ACTIVE: begin
                if (!radio_en_s2) begin
                    w_go_pd = 1'b1;
                end else if (!pll_lock) begin
                    w_set_err = 1'b1;
                    w_lockout = 1'b1;
                    w_go_pd   = 1'b1;
                end else if (rx_en_s2 != r_dir) begin
                    w_nxt_state = S_GAP;
                    w_rx_en     = 1'b0;
                    w_tx_en     = 1'b0;
                    w_ready     = 1'b0;
                    w_load      = 1'b1;
                    w_load_val  = LD_GAP;
                end
            end
            S_PWR_DN: begin
                if (w_zero) begin
                    w_nxt_state = S_IDLE;
                    w_ldo_en    = 1'b0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_ldo_en    = 1'b0;
                w_pll_en    = 1'b0;
                w_rx_en     = 1'b0;
                w_tx_en     = 1'b0;
                w_ready     = 1'b0;
            end
        endcase
        // LDO held on while everything downstream is already off
        if (w_go_pd) begin
            w_nxt_state = S_PWR_DN;
            w_ldo_en    = 1'b1;
            w_pll_en    = 1'b0;
            w_rx_en     = 1'b0;
            w_tx_en     = 1'b0;
            w_ready     = 1'b0;
            w_load      = 1'b1;
            w_load_val  = LD_PD;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ldo_en  <= 1'b0;
            r_pll_en  <= 1'b0;
            r_rx_en   <= 1'b0;
            r_tx_en   <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_lockout <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_ldo_en  <= w_ldo_en;
            r_pll_en  <= w_pll_en;
            r_rx_en   <= w_rx_en;
            r_tx_en   <= w_tx_en;
            r_ready   <= w_ready;
            r_lockout <= w_lockout;
            r_dir     <= w_dir;
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign ldo_en      = r_ldo_en;
    assign pll_en      = r_pll_en;
    assign rx_path_en  = r_rx_en;
    assign tx_path_en  = r_tx_en;
    assign radio_ready = r_ready;
    assign timeout_err = r_err;
    assign state_o     = r_state;

endmodule
